// File: rtl/fabric_cfg_loader.sv
// fabric_cfg_loader: streams 32-bit config words LSB-first into the CLB chain, then the connection chain.
// Define CFG_LOADER_CRC_EN to run CRC-16-CCITT over all shifted bits and verify a trailing check word.
module fabric_cfg_loader #(
  parameter int unsigned CLB_CHAIN_LEN  = 64,
  parameter int unsigned CONN_CHAIN_LEN = 128
) (
  input  logic        scan_clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] cfg_data,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  output logic        clb_scan_in,
  output logic        clb_scan_en,
  output logic        conn_scan_in,
  output logic        conn_scan_en,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int unsigned MAX_LEN = (CLB_CHAIN_LEN > CONN_CHAIN_LEN) ? CLB_CHAIN_LEN : CONN_CHAIN_LEN;
  localparam int unsigned CNT_W   = $clog2(MAX_LEN);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_CLB,
    LOAD_CONN,
    CHECK,
    DONE
  } state_t;

  state_t            state, state_next;
  logic [30:0]       sr;
  logic [4:0]        rem;
  logic [CNT_W-1:0]  bit_cnt;
  logic              shift_en, chain_last, accept, start_acc;
  logic              in_load, to_conn, load_word, shift_more, present, out_bit;

  assign shift_en  = clb_scan_en | conn_scan_en;
  assign accept    = cfg_valid & cfg_ready;
  assign start_acc = (state == IDLE) & start;
  assign in_load   = (state == LOAD_CLB) | (state == LOAD_CONN);

  always_comb begin
    chain_last = 1'b0;
    if (shift_en) begin
      if (state == LOAD_CLB) chain_last = (bit_cnt == CNT_W'(CLB_CHAIN_LEN - 1));
      else                   chain_last = (bit_cnt == CNT_W'(CONN_CHAIN_LEN - 1));
    end
  end

  always_ff @(posedge scan_clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:      if (start) state_next = LOAD_CLB;
      LOAD_CLB:  if (chain_last) state_next = LOAD_CONN;
`ifdef CFG_LOADER_CRC_EN
      LOAD_CONN: if (chain_last) state_next = CHECK;
`else
      LOAD_CONN: if (chain_last) state_next = DONE;
`endif
      CHECK:     if (accept) state_next = DONE;
      DONE:      state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // The final connection bit cannot be followed by another chain word, so
  // ready stays low there; the next word (if any) is the check word.
  always_comb begin
    cfg_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      LOAD_CLB: begin
        busy      = 1'b1;
        cfg_ready = (rem == '0);
      end
      LOAD_CONN: begin
        busy      = 1'b1;
        cfg_ready = (rem == '0) & ~chain_last;
      end
      CHECK: begin
        busy = 1'b1;
`ifdef CFG_LOADER_CRC_EN
        cfg_ready = 1'b1;
`endif
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Target chain follows the next state so a word accepted on the last CLB
  // bit lands entirely in the connection chain.
  assign to_conn    = (state_next == LOAD_CONN);
  assign load_word  = accept & ((state_next == LOAD_CLB) | (state_next == LOAD_CONN));
  assign shift_more = ~load_word & in_load & (rem != '0);
  assign present    = load_word | shift_more;
  assign out_bit    = load_word ? cfg_data[0] : sr[0];

  always_ff @(posedge scan_clk or negedge rst_n) begin
    if (!rst_n) begin
      sr           <= '0;
      rem          <= '0;
      bit_cnt      <= '0;
      clb_scan_in  <= 1'b0;
      clb_scan_en  <= 1'b0;
      conn_scan_in <= 1'b0;
      conn_scan_en <= 1'b0;
    end else begin
      if (start_acc)     bit_cnt <= '0;
      else if (shift_en) bit_cnt <= chain_last ? '0 : bit_cnt + CNT_W'(1);

      if (load_word) begin
        sr  <= cfg_data[31:1];
        rem <= 5'd31;
      end else if (shift_more) begin
        sr  <= {1'b0, sr[30:1]};
        rem <= rem - 5'd1;
      end

      clb_scan_en  <= present & ~to_conn;
      conn_scan_en <= present & to_conn;
      if (present && !to_conn) clb_scan_in  <= out_bit;
      if (present && to_conn)  conn_scan_in <= out_bit;
    end
  end

`ifdef CFG_LOADER_CRC_EN
  logic [15:0] crc;
  logic        crc_in, crc_fb;

  assign crc_in = clb_scan_en ? clb_scan_in : conn_scan_in;
  assign crc_fb = crc[15] ^ crc_in;

  always_ff @(posedge scan_clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= '0;
      err <= 1'b0;
    end else if (start_acc) begin
      crc <= 16'hFFFF;
      err <= 1'b0;
    end else begin
      if (shift_en) crc <= {crc[14:0], 1'b0} ^ (crc_fb ? 16'h1021 : 16'h0000);
      if (state == CHECK && accept && cfg_data[15:0] != crc) err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_fabric_cfg_loader.sv
// Directed bench for fabric_cfg_loader (default parameters); honours CFG_LOADER_CRC_EN when defined.
`timescale 1ns/1ps
module tb_fabric_cfg_loader;

`ifdef CFG_LOADER_CRC_EN
  localparam int NW        = 7;
  localparam int DONE_BASE = 195;
`else
  localparam int NW        = 6;
  localparam int DONE_BASE = 194;
`endif

  logic        scan_clk = 1'b0;
  logic        rst_n    = 1'b0;
  logic        start    = 1'b0;
  logic [31:0] cfg_data = '0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready, clb_scan_in, clb_scan_en, conn_scan_in, conn_scan_en, busy, done, err;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [31:0]  words [7];
  logic [63:0]  clb_got;
  logic [127:0] conn_got;
  int nclb, nconn, overlap, first_en, last_en, en_cnt, done_cnt, done_c, finished;
  logic busy_c1, err_c1, busy_at_done, err_at_done, done_after, busy_after, ready_after;

  always #5 scan_clk = ~scan_clk;

  fabric_cfg_loader #(.CLB_CHAIN_LEN(64), .CONN_CHAIN_LEN(128)) dut (
    .scan_clk(scan_clk), .rst_n(rst_n), .start(start), .cfg_data(cfg_data), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready), .clb_scan_in(clb_scan_in), .clb_scan_en(clb_scan_en),
    .conn_scan_in(conn_scan_in), .conn_scan_en(conn_scan_en), .busy(busy), .done(done), .err(err)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [15:0] crc_model();
    logic [15:0] c = 16'hFFFF;
    logic fb;
    for (int w = 0; w < 6; w++)
      for (int b = 0; b < 32; b++) begin
        fb = c[15] ^ words[w][b];
        c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end
    return c;
  endfunction

  // One load: stall_after = accepted-word count after which valid drops for
  // stall_cycles ready-high cycles; start_at re-pulses start; reset_bit aborts.
  task automatic run_load(input int n, input int stall_after, input int stall_cycles,
                          input int start_at, input int reset_bit);
    int idx = 0, stall_left = 0, c = 0, abort_en = 0;
    bit stalling = 0, acc, st_rdy;
    nclb = 0; nconn = 0; overlap = 0; first_en = -1; last_en = -1; en_cnt = 0;
    done_cnt = 0; done_c = -1; finished = 0; clb_got = '0; conn_got = '0;
    busy_c1 = 0; err_c1 = 1; busy_at_done = 1; err_at_done = 0;
    @(posedge scan_clk); #1;
    start = 1'b1; cfg_valid = 1'b1; cfg_data = words[0];
    while (finished == 0 && c < 3000) begin
      @(negedge scan_clk);
      if (clb_scan_en && conn_scan_en) overlap++;
      if (clb_scan_en) begin
        if (nclb < 64) clb_got[nclb] = clb_scan_in;
        nclb++;
      end
      if (conn_scan_en) begin
        if (nconn < 128) conn_got[nconn] = conn_scan_in;
        nconn++;
      end
      if (clb_scan_en || conn_scan_en) begin
        if (en_cnt == 0) first_en = c;
        last_en = c;
        en_cnt++;
      end
      if (c == 1) begin busy_c1 = busy; err_c1 = err; end
      if (done) begin
        done_cnt++; done_c = c; busy_at_done = busy; err_at_done = err; finished = 1;
      end
      if (reset_bit >= 0 && nclb == reset_bit) begin
        rst_n = 1'b0;
        #1;
        check("rst_outputs", {cfg_ready, clb_scan_in, clb_scan_en, conn_scan_in, conn_scan_en,
                              busy, done, err}, 8'h00);
        @(negedge scan_clk);
        check("rst_held", {clb_scan_en, conn_scan_en, busy}, 3'b000);
        @(posedge scan_clk); #1;
        rst_n = 1'b1; start = 1'b0; cfg_valid = 1'b0;
        repeat (4) begin
          @(negedge scan_clk);
          if (clb_scan_en || conn_scan_en) abort_en++;
        end
        check("rst_no_scan_en", abort_en, 0);
        return;
      end
      acc    = cfg_valid && cfg_ready;
      st_rdy = stalling && !cfg_valid && cfg_ready;
      @(posedge scan_clk); #1;
      c++;
      start = 1'b0;
      if (acc) begin
        idx++;
        if (idx == start_at) start = 1'b1;
        if (idx == stall_after) begin stalling = 1; stall_left = stall_cycles; end
      end
      if (st_rdy) stall_left--;
      if (stalling && stall_left <= 0) stalling = 0;
      cfg_valid = (idx < n) && !stalling;
      cfg_data  = (idx < n) ? words[idx] : '0;
    end
    check("load_finished", finished, 1);
    cfg_valid = 1'b0; start = 1'b0;
    @(negedge scan_clk);
    done_after = done; busy_after = busy; ready_after = cfg_ready;
  endtask

  task automatic check_load(input string p, input int stall, input logic exp_err);
    check({p, "_clb_bits"},  clb_got,  {words[1], words[0]});
    check({p, "_conn_bits"}, conn_got, {words[5], words[4], words[3], words[2]});
    check({p, "_clb_count"},  nclb,  64);
    check({p, "_conn_count"}, nconn, 128);
    check({p, "_overlap"},    overlap, 0);
    check({p, "_first_bit"},  first_en, 2);
    check({p, "_gaps"},       last_en - first_en + 1 - en_cnt, stall);
    check({p, "_done_cycle"}, done_c, DONE_BASE + stall);
    check({p, "_done_count"}, done_cnt, 1);
    check({p, "_busy_c1"},    busy_c1, 1'b1);
    check({p, "_err_cleared"}, err_c1, 1'b0);
    check({p, "_busy_at_done"}, busy_at_done, 1'b0);
    check({p, "_err_at_done"},  err_at_done, exp_err);
    check({p, "_idle_after"}, {done_after, busy_after, ready_after}, 3'b000);
  endtask

  initial begin
    words[0] = 32'hDEADBEEF; words[1] = 32'h00000001; words[2] = 32'h80000000;
    words[3] = 32'hA5A55A5A; words[4] = 32'hFFFF0000; words[5] = 32'h12345678;
    words[6] = {16'h0000, crc_model()};

    repeat (3) @(negedge scan_clk);
    check("reset_state", {cfg_ready, clb_scan_in, clb_scan_en, conn_scan_in, conn_scan_en,
                          busy, done, err}, 8'h00);
    @(posedge scan_clk); #1;
    rst_n = 1'b1;
    repeat (2) @(negedge scan_clk);
    check("idle_state", {cfg_ready, clb_scan_en, conn_scan_en, busy, done}, 5'b00000);

    run_load(NW, 0, 0, 0, -1);
    check_load("basic", 0, 1'b0);

    run_load(NW, 2, 5, 0, -1);
    check_load("stall", 5, 1'b0);

    run_load(NW, 0, 0, 3, -1);
    check_load("restart", 0, 1'b0);

`ifdef CFG_LOADER_CRC_EN
    words[6] = words[6] ^ 32'h1;
    run_load(NW, 0, 0, 0, -1);
    check_load("crc_bad", 0, 1'b1);
    repeat (5) @(negedge scan_clk);
    check("err_sticky", err, 1'b1);
    words[6] = words[6] ^ 32'h1;
    run_load(NW, 0, 0, 0, -1);
    check_load("crc_ok", 0, 1'b0);
`endif

    run_load(NW, 0, 0, 0, 40);
    run_load(NW, 0, 0, 0, -1);
    check_load("after_rst", 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
